// File: rtl/uart_tx_ser.sv
// UART transmit serialiser: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Latency: the start bit and busy appear on the edge that accepts the frame; done pulses on the final stop edge.
// Backpressure: Data_Valid is only accepted in IDLE; requests while busy are dropped, never queued.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, overrides everything including a frame in flight
//   P_DATA     byte to send, captured on acceptance
//   Data_Valid request to send P_DATA
//   PAR_EN     1 = insert parity bit (captured on acceptance)
//   PAR_TYP    0 = even, 1 = odd parity (captured on acceptance)
//   prescale   clocks per bit, 0 treated as 1 (captured on acceptance)
//   STOP2      only with UART_TX_TWO_STOP_EN defined: 1 = two stop bits (captured on acceptance)
//   TX_OUT     serial line, idle high, registered
//   busy       frame in progress, registered
//   done       one-clock pulse when the last stop bit completes, registered
//
// Build option: define UART_TX_TWO_STOP_EN to add the STOP2 input. Without it every
// frame has exactly one stop bit.

module uart_tx_ser #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [PRESC_W-1:0]    prescale,
`ifdef UART_TX_TWO_STOP_EN
   input  logic                  STOP2,
`endif
   output logic                  TX_OUT,
   output logic                  busy,
   output logic                  done
);

   // Frame states, kept as plain constants so the encoding is visible in waveforms.
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   logic [2:0]            state;
   logic [PRESC_W-1:0]    bit_cnt;     // clocks elapsed in the current bit
   logic [PRESC_W-1:0]    last_cnt;    // captured prescale minus one, bit ends when bit_cnt reaches it
   logic [DATA_WIDTH-1:0] shreg;       // remaining data bits, bit 0 is the one on the line
   logic [IDX_W-1:0]      data_idx;    // index of the data bit currently being sent
   logic                  par_en_q;
   logic                  par_bit_q;   // parity bit resolved at capture time
   logic                  stop2_q;
   logic                  stop_idx;    // 0 = first stop bit, 1 = second stop bit
   logic                  bit_end;
   logic                  stop2_in;
   logic [PRESC_W-1:0]    last_cnt_in;

`ifdef UART_TX_TWO_STOP_EN
   assign stop2_in = STOP2;
`else
   assign stop2_in = 1'b0;
`endif

   // A prescale of zero would give a zero-length bit; clamp it to one clock.
   assign last_cnt_in = (prescale == '0) ? '0 : (prescale - PRESC_W'(1));

   assign bit_end = (bit_cnt == last_cnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         last_cnt  <= '0;
         shreg     <= '0;
         data_idx  <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
         stop_idx  <= 1'b0;
         TX_OUT    <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;

         // The bit timer only runs while a frame is on the line and wraps every bit.
         if (state != S_IDLE) begin
            bit_cnt <= bit_end ? '0 : (bit_cnt + PRESC_W'(1));
         end

         case (state)
            S_IDLE: begin
               if (Data_Valid) begin
                  // Everything the frame depends on is frozen here, so later
                  // input changes cannot corrupt the frame in flight.
                  shreg     <= P_DATA;
                  par_en_q  <= PAR_EN;
                  par_bit_q <= (^P_DATA) ^ PAR_TYP;
                  last_cnt  <= last_cnt_in;
                  stop2_q   <= stop2_in;
                  stop_idx  <= 1'b0;
                  data_idx  <= '0;
                  bit_cnt   <= '0;
                  state     <= S_START;
                  TX_OUT    <= 1'b0;
                  busy      <= 1'b1;
               end
            end

            S_START: begin
               if (bit_end) begin
                  state  <= S_DATA;
                  TX_OUT <= shreg[0];
               end
            end

            S_DATA: begin
               if (bit_end) begin
                  if (data_idx == LAST_IDX) begin
                     if (par_en_q) begin
                        state  <= S_PARITY;
                        TX_OUT <= par_bit_q;
                     end else begin
                        state  <= S_STOP;
                        TX_OUT <= 1'b1;
                     end
                  end else begin
                     // Drive the next bit directly from the pre-shift value so the
                     // line changes on the same edge the shift happens.
                     shreg    <= shreg >> 1;
                     TX_OUT   <= shreg[1];
                     data_idx <= data_idx + IDX_W'(1);
                  end
               end
            end

            S_PARITY: begin
               if (bit_end) begin
                  state  <= S_STOP;
                  TX_OUT <= 1'b1;
               end
            end

            S_STOP: begin
               if (bit_end) begin
                  if (stop2_q && !stop_idx) begin
                     // Line is already high; just run one more bit period.
                     stop_idx <= 1'b1;
                  end else begin
                     state  <= S_IDLE;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     TX_OUT <= 1'b1;
                  end
               end
            end

            default: begin
               state  <= S_IDLE;
               TX_OUT <= 1'b1;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_ser.md
Name: uart_tx_ser

Overview:
UART transmit path: accepts one parallel byte and serialises it onto a single line, LSB first, as start bit, 8 data bits, optional parity, then stop. It is the transmit counterpart of the oversampled UART receive chain and runs on the same clock. Bit timing comes from an internal prescale counter, so one bit lasts `prescale` clocks, matching the receiver's oversampling ratio. Sits between the system-side transmit FIFO/controller and the TX pad.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESC_W, 6, width of `prescale`.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- P_DATA  in  DATA_WIDTH  byte to send; sampled only on acceptance.
- Data_Valid  in  1  request to send P_DATA.
- PAR_EN  in  1  1 = parity bit inserted; sampled on acceptance.
- PAR_TYP  in  1  0 = even, 1 = odd; sampled on acceptance.
- prescale  in  PRESC_W  clocks per bit; sampled on acceptance.
- TX_OUT  out  1  serial line; idle high.
- busy  out  1  frame in progress.
- done  out  1  one-clock pulse when the final stop bit completes.

Behaviour:
- Reset, checked on each rising clk with rst=1:
  - state=IDLE, TX_OUT=1, busy=0, done=0.
  - All counters and capture registers are cleared.
  - Reset has priority over every other event, including mid-frame; the line returns high on that edge.
- Outputs: all registered; no combinational path from inputs to outputs.
- Acceptance:
  - A frame is accepted on the edge where state=IDLE and Data_Valid=1.
  - On that edge P_DATA, PAR_EN, PAR_TYP and prescale are captured.
  - Data_Valid while busy=1 is ignored; it is not queued.
- Latency: the start bit (TX_OUT=0) and busy=1 both appear on the edge that accepts the frame, i.e. visible in the cycle after the Data_Valid sample.
- Bit period: Pq = captured prescale; Pq=0 is treated as 1. Each bit holds TX_OUT for exactly Pq clocks. The bit counter counts 0..Pq-1 and wraps.
- States:
  - IDLE: TX_OUT=1, busy=0.
  - START: TX_OUT=0 for Pq clocks, then go to DATA.
  - DATA: outputs shift-register bit 0, shifting right once per bit period (LSB first). After DATA_WIDTH bits, go to PARITY if PAR_EN, else STOP.
  - PARITY: TX_OUT = XOR(captured data) XOR PAR_TYP, for Pq clocks, then go to STOP.
  - STOP: TX_OUT=1 for Pq clocks, then go to IDLE. On that same edge busy=0 and done=1 for one clock.
- Frame length: (1 + DATA_WIDTH + PAR_EN + stop bits) × Pq clocks.
- Minimum inter-frame gap: one IDLE clock, because a Data_Valid held high is accepted in the IDLE cycle after done.
- Changes to P_DATA, PAR_EN, PAR_TYP or prescale mid-frame have no effect on the current frame.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: adds input `STOP2` (1 bit), captured on acceptance. STOP2=1 holds the stop level for 2×Pq clocks; done pulses at the end of the second stop bit.
- Undefined: the port is absent and the frame always has exactly one stop bit.

Test Plan:
- rst=1 for 2 clocks → TX_OUT=1, busy=0, done=0; hold 20 clocks with Data_Valid=0 → no change.
- prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, Data_Valid pulse → line sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 8 clocks; busy high for 88 clocks; done pulses once.
- prescale=16, PAR_EN=1, PAR_TYP=1, P_DATA=0x00 → parity bit=1, frame 176 clocks; same frame with PAR_EN=0 → no parity bit, 160 clocks.
- Data_Valid held high with P_DATA=0x3C then 0xC3, prescale=4, PAR_EN=0 → two frames separated by exactly one idle-high clock; a Data_Valid pulse mid-frame is ignored; prescale=0 → 1 clock per bit.
- rst asserted during DATA bit 4 of 0xFF → next edge TX_OUT=1, busy=0, no done pulse; a new Data_Valid then sends a complete fresh frame.
- With UART_TX_TWO_STOP_EN defined, STOP2=1, prescale=8, PAR_EN=0 → stop high for 16 clocks, total frame 88 clocks, done at its end.
